cpu_bus_arbiter: RTL and testbench
==================================

# cpu_bus_arbiter

Parametrised N-port arbiter for the CPU data-bus protocol (request/address/write/wstrb/wdata out; rdata/busy/valid in). It merges several bus masters onto one memory-side bus: CPU data port, icache refill, future DMA/second core. Round-robin grant and in-order read-return routing via an outstanding-read ID FIFO generalise the single-master, point-to-point bus the CPU drives today.

## Interface
- NUM_PORTS, 2, number of upstream masters (1..8)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width (multiple of 8); strobe width = DATA_WIDTH/8
- MAX_OUTSTANDING, 4, read responses in flight (power of 2, ≥1)

Ports (per-port buses are packed, port i at slice i):
- clock  in  1  system clock; one clock only
- reset  in  1  synchronous, active-high
- up_request  in  NUM_PORTS  master i requests an access
- up_address  in  NUM_PORTS*ADDR_WIDTH  addresses
- up_write  in  NUM_PORTS  1 = write, 0 = read
- up_wstrb  in  NUM_PORTS*DATA_WIDTH/8  byte enables
- up_wdata  in  NUM_PORTS*DATA_WIDTH  write data
- up_busy  out  NUM_PORTS  request not accepted this cycle
- up_rdata  out  DATA_WIDTH  read data, shared by all ports
- up_valid  out  NUM_PORTS  up_rdata valid for port i
- mem_request  out  1  ; mem_address out ADDR_WIDTH ; mem_write out 1 ; mem_wstrb out DATA_WIDTH/8 ; mem_wdata out DATA_WIDTH
- mem_rdata  in  DATA_WIDTH ; mem_busy  in  1 ; mem_valid  in  1
- err_stray_valid  out  1  sticky: mem_valid seen with no read outstanding

## Operation
- Handshake, both sides: transfer accepted in a cycle where request=1 and busy=0; master holds request and all fields stable until accepted.
- Grant: combinational round-robin over requesting ports, search starting at rr_ptr. Eligible = up_request[i] and (up_write[i] or FIFO not full).
- mem_* = fields of granted port; mem_request = 1 iff some port eligible.
- up_busy[i] = 0 only for granted port when mem_busy=0; all others 1.
- On acceptance: rr_ptr <= (granted + 1) mod NUM_PORTS; if read, push granted index into ID FIFO.
- Read return: mem_valid pops FIFO head h; up_valid[h]=1, up_rdata=mem_rdata same cycle. Responses in order, one per mem_valid.
- Full FIFO: reads blocked (not eligible, busy=1); writes still granted. Pop and push in the same cycle when full: push blocked (conservative; no full-bypass).
- Empty FIFO and mem_valid=1: no up_valid, no pop, err_stray_valid <= 1 until reset.
- Writes produce no response and never touch the FIFO.
- Reset: rr_ptr=0, FIFO empty, err_stray_valid=0; while reset high: mem_request=0, up_busy all 1, up_valid all 0, mem_address/wdata/wstrb/write=0, up_rdata=0.
- Reset mid-operation: outstanding reads discarded; late mem_valid after reset flags err_stray_valid (memory side must be reset together).

## Timing
- Request path: zero-cycle combinational (up_* to mem_*, mem_busy to up_busy).
- Response path: zero-cycle combinational (mem_valid/mem_rdata to up_valid/up_rdata).
- State changes (rr_ptr, FIFO, err flag) only at clock edge on accepted transfer/valid.
- Throughput: one accepted transfer and one response per cycle.
- Fairness: a continuously eligible port is granted within NUM_PORTS accepted transfers.
- NUM_PORTS=1: rr_ptr constant 0; behaves as pass-through plus error flag.

## Structure
- Shared package cpu_bus_pkg: port-index width function (clog2, min 1), bus field width constants.
- Sub-module cpu_bus_id_fifo: synchronous FIFO, depth MAX_OUTSTANDING, width = port-index width, full/empty, push blocked when full regardless of pop.
- Round-robin selector inline in cpu_bus_arbiter.

## Test plan
- NUM_PORTS=2, both request reads continuously, mem_busy=0 → grants alternate 0,1,0,1; FIFO entries 0,1,0,1; four mem_valid with rdata 0xA..0xD → up_valid[0] gets 0xA,0xC, up_valid[1] gets 0xB,0xD.
- MAX_OUTSTANDING=4, port 0 issues 5 reads without responses → 5th held (up_busy[0]=1, mem_request=0); port 1 write 0x1234 at 0x40 with wstrb 4'b0011 still passes.
- Full FIFO, same-cycle mem_valid and pending read → pop occurs, read accepted next cycle, not same cycle.
- mem_busy=1 for 3 cycles with port 1 requesting → up_busy[1]=1 throughout, mem_address stable, rr_ptr unchanged; accepted on cycle 4.
- mem_valid with empty FIFO → all up_valid=0, err_stray_valid=1 and stays 1 until reset, cleared to 0 by reset.
- Reset asserted with 2 reads outstanding → next cycle FIFO empty, rr_ptr=0, mem_request=0, all up_busy=1 while reset high.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// ---------------------------------------------------------------------------
// cpu_bus_pkg
// Shared definitions for the CPU data-bus arbiter slice.
//   - Default bus field widths and arbiter sizing constants.
//   - port_idx_width(): bits needed to name one of N items (clog2, min 1),
//     used for port indices and FIFO pointers.
//   - strb_width(): byte-enable width for a given data width.
// ---------------------------------------------------------------------------
package cpu_bus_pkg;

  localparam int BUS_ADDR_WIDTH      = 32;
  localparam int BUS_DATA_WIDTH      = 32;
  localparam int BUS_NUM_PORTS       = 2;
  localparam int BUS_MAX_OUTSTANDING = 4;

  // A single item still needs one bit so that index signals never have
  // zero width.
  function automatic int port_idx_width(input int num_items);
    if (num_items <= 2) begin
      return 1;
    end
    return $clog2(num_items);
  endfunction

  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/cpu_bus_id_fifo.sv
// ---------------------------------------------------------------------------
// cpu_bus_id_fifo
// Synchronous FIFO holding the port index of every read that has been
// accepted by memory but not yet answered. The head entry tells the
// arbiter which master the next mem_valid belongs to.
//
// Ports:
//   clock      in   system clock
//   reset      in   synchronous active-high reset, empties the FIFO
//   push       in   store push_data (ignored when full, even if popping)
//   push_data  in   WIDTH-bit port index
//   pop        in   discard the head entry (ignored when empty)
//   head_data  out  current head entry
//   full       out  DEPTH entries stored
//   empty      out  no entries stored
// ---------------------------------------------------------------------------
module cpu_bus_id_fifo
  import cpu_bus_pkg::*;
#(
  parameter int DEPTH = BUS_MAX_OUTSTANDING,
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = port_idx_width(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign head_data = storage[rd_ptr];

  // Push is refused whenever the FIFO is full, even if a pop frees a slot
  // in the same cycle; this keeps full a pure function of stored state.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Entry storage carries no reset: an entry is only ever read after
  // it has been written.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      storage[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap explicitly at DEPTH-1 and the occupancy counter tracks
  // push/pop so that full and empty are unambiguous.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// ---------------------------------------------------------------------------
// cpu_bus_arbiter
// Merges NUM_PORTS CPU-data-bus masters onto one memory-side bus.
// Requests are granted round-robin; read responses come back in order
// and are routed to the issuing master using an ID FIFO of outstanding
// reads. Request and response paths are purely combinational.
//
// Ports (per-port buses packed, port i at slice i):
//   clock, reset                 system clock, synchronous active-high reset
//   up_request/address/write/
//   up_wstrb/up_wdata       in   master-side request fields
//   up_busy                 out  per-port "not accepted this cycle"
//   up_rdata                out  shared read data
//   up_valid                out  per-port read data valid
//   mem_request/address/write/
//   mem_wstrb/mem_wdata     out  memory-side request (granted port)
//   mem_rdata/busy/valid    in   memory-side response and backpressure
//   err_stray_valid         out  sticky: mem_valid with no read outstanding
// ---------------------------------------------------------------------------
module cpu_bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int NUM_PORTS       = BUS_NUM_PORTS,
  parameter int ADDR_WIDTH      = BUS_ADDR_WIDTH,
  parameter int DATA_WIDTH      = BUS_DATA_WIDTH,
  parameter int MAX_OUTSTANDING = BUS_MAX_OUTSTANDING
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [NUM_PORTS-1:0]                   up_request,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]        up_address,
  input  logic [NUM_PORTS-1:0]                   up_write,
  input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0]    up_wstrb,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]        up_wdata,
  output logic [NUM_PORTS-1:0]                   up_busy,
  output logic [DATA_WIDTH-1:0]                  up_rdata,
  output logic [NUM_PORTS-1:0]                   up_valid,
  output logic                                   mem_request,
  output logic [ADDR_WIDTH-1:0]                  mem_address,
  output logic                                   mem_write,
  output logic [(DATA_WIDTH/8)-1:0]              mem_wstrb,
  output logic [DATA_WIDTH-1:0]                  mem_wdata,
  input  logic [DATA_WIDTH-1:0]                  mem_rdata,
  input  logic                                   mem_busy,
  input  logic                                   mem_valid,
  output logic                                   err_stray_valid
);

  localparam int IW = port_idx_width(NUM_PORTS);
  localparam int SW = strb_width(DATA_WIDTH);

  logic [IW-1:0]        rr_ptr;
  logic [IW-1:0]        grant_idx;
  logic                 grant_valid;
  logic [NUM_PORTS-1:0] eligible;
  logic [IW-1:0]        head_idx;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 accept;
  logic                 push_read;
  logic                 pop_resp;
  logic                 stray;
  logic                 err_q;
  int                   cand;

  // A read can only be granted while the ID FIFO has room for its
  // response slot; writes never need one.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      eligible[i] = up_request[i] && (up_write[i] || !fifo_full);
    end
  end

  // Round-robin search starting at rr_ptr; the first eligible port wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_PORTS) begin
        cand = cand - NUM_PORTS;
      end
      if (!grant_valid && eligible[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = IW'(cand);
      end
    end
  end

  // Request path: forward the granted port's fields and release only its
  // busy when memory can take the transfer. Everything is held quiet
  // while reset is high.
  always_comb begin
    mem_request = 1'b0;
    mem_address = '0;
    mem_write   = 1'b0;
    mem_wstrb   = '0;
    mem_wdata   = '0;
    up_busy     = '1;
    accept      = 1'b0;
    push_read   = 1'b0;
    if (!reset && grant_valid) begin
      mem_request = 1'b1;
      mem_address = up_address[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      mem_write   = up_write[grant_idx];
      mem_wstrb   = up_wstrb[int'(grant_idx)*SW +: SW];
      mem_wdata   = up_wdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
      if (!mem_busy) begin
        up_busy[grant_idx] = 1'b0;
        accept             = 1'b1;
        push_read          = !up_write[grant_idx];
      end
    end
  end

  // Response path: each mem_valid belongs to the oldest outstanding read.
  // A response with nothing outstanding is dropped and flagged instead.
  always_comb begin
    up_valid = '0;
    up_rdata = '0;
    pop_resp = 1'b0;
    stray    = 1'b0;
    if (!reset && mem_valid) begin
      if (!fifo_empty) begin
        pop_resp           = 1'b1;
        up_valid[head_idx] = 1'b1;
        up_rdata           = mem_rdata;
      end else begin
        stray = 1'b1;
      end
    end
  end

  // The pointer moves past the port just served so it goes to the back
  // of the queue; the stray flag holds until the next reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr <= '0;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        rr_ptr <= (grant_idx == IW'(NUM_PORTS - 1)) ? '0 : grant_idx + IW'(1);
      end
      if (stray) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_stray_valid = err_q;

  cpu_bus_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IW)
  ) u_id_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_read),
    .push_data (grant_idx),
    .pop       (pop_resp),
    .head_data (head_idx),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cpu_bus_arbiter
// Directed bench for cpu_bus_arbiter with two ports and four outstanding
// reads. Each vector drives one cycle of inputs after the falling edge,
// compares the combinational outputs and registered flag before the next
// rising edge, and then lets that edge update the arbiter state.
// ---------------------------------------------------------------------------
module tb_cpu_bus_arbiter;

  localparam int NP = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int MO = 4;

  logic              clock;
  logic              reset;
  logic [NP-1:0]     up_request;
  logic [NP*AW-1:0]  up_address;
  logic [NP-1:0]     up_write;
  logic [NP*SW-1:0]  up_wstrb;
  logic [NP*DW-1:0]  up_wdata;
  logic [NP-1:0]     up_busy;
  logic [DW-1:0]     up_rdata;
  logic [NP-1:0]     up_valid;
  logic              mem_request;
  logic [AW-1:0]     mem_address;
  logic              mem_write;
  logic [SW-1:0]     mem_wstrb;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata;
  logic              mem_busy;
  logic              mem_valid;
  logic              err_stray_valid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  wr;
    logic        busy;
    logic        valid;
    logic [31:0] rdata;
    int          exp_gnt;
    logic [1:0]  exp_ubusy;
    logic [1:0]  exp_uvalid;
    logic [31:0] exp_urdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  cpu_bus_arbiter #(
    .NUM_PORTS       (NP),
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .up_request      (up_request),
    .up_address      (up_address),
    .up_write        (up_write),
    .up_wstrb        (up_wstrb),
    .up_wdata        (up_wdata),
    .up_busy         (up_busy),
    .up_rdata        (up_rdata),
    .up_valid        (up_valid),
    .mem_request     (mem_request),
    .mem_address     (mem_address),
    .mem_write       (mem_write),
    .mem_wstrb       (mem_wstrb),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_busy        (mem_busy),
    .mem_valid       (mem_valid),
    .err_stray_valid (err_stray_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Fixed per-port request fields: port 0 at 0x100, port 1 writes 0x1234
  // at 0x40 with the low two bytes enabled.
  function automatic logic [31:0] port_addr(input int p);
    return (p == 0) ? 32'h0000_0100 : 32'h0000_0040;
  endfunction

  function automatic logic [31:0] port_wdata(input int p);
    return (p == 0) ? 32'hAAAA_0000 : 32'h0000_1234;
  endfunction

  function automatic logic [3:0] port_wstrb(input int p);
    return (p == 0) ? 4'b1111 : 4'b0011;
  endfunction

  assign up_address = {port_addr(1), port_addr(0)};
  assign up_wdata   = {port_wdata(1), port_wdata(0)};
  assign up_wstrb   = {port_wstrb(1), port_wstrb(0)};

  function automatic vec_t mk(input string n, input logic rst, input logic [1:0] req,
                              input logic [1:0] wr, input logic busy, input logic valid,
                              input logic [31:0] rdata, input int gnt,
                              input logic [1:0] ub, input logic [1:0] uv,
                              input logic [31:0] ur, input logic err);
    vec_t v;
    v.name = n; v.rst = rst; v.req = req; v.wr = wr; v.busy = busy;
    v.valid = valid; v.rdata = rdata; v.exp_gnt = gnt; v.exp_ubusy = ub;
    v.exp_uvalid = uv; v.exp_urdata = ur; v.exp_err = err;
    return v;
  endfunction

  task automatic compareField(input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", what, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clock);
    reset      = v.rst;
    up_request = v.req;
    up_write   = v.wr;
    mem_busy   = v.busy;
    mem_valid  = v.valid;
    mem_rdata  = v.rdata;
    #1;
  endtask

  task automatic checkOutput(input vec_t v);
    logic        exp_mreq;
    logic [31:0] exp_addr;
    logic        exp_mwrite;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    exp_mreq   = (v.exp_gnt >= 0);
    exp_addr   = exp_mreq ? port_addr(v.exp_gnt) : 32'h0;
    exp_mwrite = exp_mreq ? v.wr[v.exp_gnt] : 1'b0;
    exp_wdata  = exp_mreq ? port_wdata(v.exp_gnt) : 32'h0;
    exp_wstrb  = exp_mreq ? port_wstrb(v.exp_gnt) : 4'h0;
    compareField({v.name, " mem_request"}, 32'(mem_request), 32'(exp_mreq));
    compareField({v.name, " up_busy"}, 32'(up_busy), 32'(v.exp_ubusy));
    compareField({v.name, " up_valid"}, 32'(up_valid), 32'(v.exp_uvalid));
    compareField({v.name, " up_rdata"}, up_rdata, v.exp_urdata);
    compareField({v.name, " mem_address"}, mem_address, exp_addr);
    compareField({v.name, " mem_write"}, 32'(mem_write), 32'(exp_mwrite));
    compareField({v.name, " mem_wdata"}, mem_wdata, exp_wdata);
    compareField({v.name, " mem_wstrb"}, 32'(mem_wstrb), 32'(exp_wstrb));
    compareField({v.name, " err_stray_valid"}, 32'(err_stray_valid), 32'(v.exp_err));
  endtask

  initial begin
    vec_t h;

    reset      = 1'b1;
    up_request = '0;
    up_write   = '0;
    mem_busy   = 1'b0;
    mem_valid  = 1'b0;
    mem_rdata  = '0;

    //                name            rst req    wr     bsy vld rdata  gnt ubusy  uvalid urdata err
    vecs.push_back(mk("reset0",        1, 2'b11, 2'b00, 0, 0, 32'h0,  -1, 2'b11, 2'b00, 32'h0,  0));
    vecs.push_back(mk("reset1",        1, 2'b11, 2'b00, 0, 0, 32'h0,  -1, 2'b11, 2'b00, 32'h0,  0));
    vecs.push_back(mk("rr_rd0",        0, 2'b11, 2'b00, 0, 0, 32'h0,   0, 2'b10, 2'b00, 32'h0,  0));
    vecs.push_back(mk("rr_rd1",        0, 2'b11, 2'b00, 0, 0, 32'h0,   1, 2'b01, 2'b00, 32'h0,  0));
    vecs.push_back(mk("rr_rd2",        0, 2'b11, 2'b00, 0, 0, 32'h0,   0, 2'b10, 2'b00, 32'h0,  0));
    vecs.push_back(mk("rr_rd3",        0, 2'b11, 2'b00, 0, 0, 32'h0,   1, 2'b01, 2'b00, 32'h0,  0));
    vecs.push_back(mk("full_pop_a",    0, 2'b11, 2'b00, 0, 1, 32'hA,  -1, 2'b11, 2'b01, 32'hA,  0));
    vecs.push_back(mk("retry_pop_b",   0, 2'b11, 2'b00, 0, 1, 32'hB,   0, 2'b10, 2'b10, 32'hB,  0));
    vecs.push_back(mk("pop_c",         0, 2'b00, 2'b00, 0, 1, 32'hC,  -1, 2'b11, 2'b01, 32'hC,  0));
    vecs.push_back(mk("pop_d",         0, 2'b00, 2'b00, 0, 1, 32'hD,  -1, 2'b11, 2'b10, 32'hD,  0));
    vecs.push_back(mk("pop_e",         0, 2'b00, 2'b00, 0, 1, 32'hE,  -1, 2'b11, 2'b01, 32'hE,  0));
    vecs.push_back(mk("p0_rd1",        0, 2'b01, 2'b00, 0, 0, 32'h0,   0, 2'b10, 2'b00, 32'h0,  0));
    vecs.push_back(mk("p0_rd2",        0, 2'b01, 2'b00, 0, 0, 32'h0,   0, 2'b10, 2'b00, 32'h0,  0));
    vecs.push_back(mk("p0_rd3",        0, 2'b01, 2'b00, 0, 0, 32'h0,   0, 2'b10, 2'b00, 32'h0,  0));
    vecs.push_back(mk("p0_rd4",        0, 2'b01, 2'b00, 0, 0, 32'h0,   0, 2'b10, 2'b00, 32'h0,  0));
    vecs.push_back(mk("p0_rd5_held",   0, 2'b01, 2'b00, 0, 0, 32'h0,  -1, 2'b11, 2'b00, 32'h0,  0));
    vecs.push_back(mk("p1_wr_pass",    0, 2'b11, 2'b10, 0, 0, 32'h0,   1, 2'b01, 2'b00, 32'h0,  0));
    vecs.push_back(mk("drain1",        0, 2'b00, 2'b00, 0, 1, 32'h11, -1, 2'b11, 2'b01, 32'h11, 0));
    vecs.push_back(mk("drain2",        0, 2'b00, 2'b00, 0, 1, 32'h22, -1, 2'b11, 2'b01, 32'h22, 0));
    vecs.push_back(mk("drain3",        0, 2'b00, 2'b00, 0, 1, 32'h33, -1, 2'b11, 2'b01, 32'h33, 0));
    vecs.push_back(mk("drain4",        0, 2'b00, 2'b00, 0, 1, 32'h44, -1, 2'b11, 2'b01, 32'h44, 0));
    vecs.push_back(mk("busy1",         0, 2'b10, 2'b00, 1, 0, 32'h0,   1, 2'b11, 2'b00, 32'h0,  0));
    vecs.push_back(mk("busy2",         0, 2'b10, 2'b00, 1, 0, 32'h0,   1, 2'b11, 2'b00, 32'h0,  0));
    vecs.push_back(mk("busy3",         0, 2'b10, 2'b00, 1, 0, 32'h0,   1, 2'b11, 2'b00, 32'h0,  0));
    vecs.push_back(mk("busy_release",  0, 2'b10, 2'b00, 0, 0, 32'h0,   1, 2'b01, 2'b00, 32'h0,  0));
    vecs.push_back(mk("p1_resp",       0, 2'b00, 2'b00, 0, 1, 32'h55, -1, 2'b11, 2'b10, 32'h55, 0));
    vecs.push_back(mk("stray",         0, 2'b00, 2'b00, 0, 1, 32'h66, -1, 2'b11, 2'b00, 32'h0,  0));
    vecs.push_back(mk("stray_sticky0", 0, 2'b00, 2'b00, 0, 0, 32'h0,  -1, 2'b11, 2'b00, 32'h0,  1));
    vecs.push_back(mk("stray_sticky1", 0, 2'b00, 2'b00, 0, 0, 32'h0,  -1, 2'b11, 2'b00, 32'h0,  1));
    vecs.push_back(mk("pre_rst_rd1",   0, 2'b10, 2'b00, 0, 0, 32'h0,   1, 2'b01, 2'b00, 32'h0,  1));
    vecs.push_back(mk("pre_rst_rd0",   0, 2'b01, 2'b00, 0, 0, 32'h0,   0, 2'b10, 2'b00, 32'h0,  1));
    vecs.push_back(mk("rst_mid",       1, 2'b11, 2'b00, 0, 1, 32'h77, -1, 2'b11, 2'b00, 32'h0,  1));
    vecs.push_back(mk("late_valid",    0, 2'b00, 2'b00, 0, 1, 32'h88, -1, 2'b11, 2'b00, 32'h0,  0));
    vecs.push_back(mk("rr_after_rst",  0, 2'b11, 2'b00, 0, 0, 32'h0,   0, 2'b10, 2'b00, 32'h0,  1));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i]);
    end

    // Writes from both ports with a memory stall in the middle: grants
    // keep alternating, the stall freezes the pointer, and writes leave
    // the one read still outstanding (from port 0) at the FIFO head.
    h = mk("wr_alt1",  0, 2'b11, 2'b11, 0, 0, 32'h0,  1, 2'b01, 2'b00, 32'h0,  1);
    applyStimulus(h); checkOutput(h);
    h = mk("wr_stall", 0, 2'b11, 2'b11, 1, 0, 32'h0,  0, 2'b11, 2'b00, 32'h0,  1);
    applyStimulus(h); checkOutput(h);
    h = mk("wr_alt2",  0, 2'b11, 2'b11, 0, 0, 32'h0,  0, 2'b10, 2'b00, 32'h0,  1);
    applyStimulus(h); checkOutput(h);
    h = mk("wr_alt3",  0, 2'b11, 2'b11, 0, 0, 32'h0,  1, 2'b01, 2'b00, 32'h0,  1);
    applyStimulus(h); checkOutput(h);
    h = mk("rd_after_wr", 0, 2'b00, 2'b00, 0, 1, 32'h99, -1, 2'b11, 2'b01, 32'h99, 1);
    applyStimulus(h); checkOutput(h);

    // The stray flag survives idle cycles and only reset clears it.
    for (int k = 0; k < 3; k++) begin
      h = mk("err_hold", 0, 2'b00, 2'b00, 0, 0, 32'h0, -1, 2'b11, 2'b00, 32'h0, 1);
      applyStimulus(h); checkOutput(h);
    end
    h = mk("err_rst", 1, 2'b00, 2'b00, 0, 0, 32'h0, -1, 2'b11, 2'b00, 32'h0, 1);
    applyStimulus(h); checkOutput(h);
    for (int k = 0; k < 2; k++) begin
      h = mk("err_cleared", 0, 2'b00, 2'b00, 0, 0, 32'h0, -1, 2'b11, 2'b00, 32'h0, 0);
      applyStimulus(h); checkOutput(h);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
